// File: rtl/mips32i_multicycle_ctrl.sv
// mips32i_multicycle_ctrl
//
// Multi-cycle control FSM for the MIPS32i core. Sequences fetch, decode,
// execute, memory and writeback over a single shared memory port. Only one
// instruction is in flight at a time.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   opcode     - IR[31:26] from the field decoder
//   funct      - IR[5:0] from the field decoder
//   alu_zero   - ALU result is zero
//   mem_ready  - memory completes the current request this cycle
//   mem_req    - memory request valid
//   mem_we     - 1 = write, 0 = read
//   iord       - memory address select: 0 = PC, 1 = ALUOut
//   ir_write   - load IR/MDR from memory read data
//   pc_write   - load PC
//   pc_src     - 0 ALU result, 1 ALUOut, 2 jump target, 3 rs
//   alu_src_a  - 0 PC, 1 rs, 2 shamt
//   alu_src_b  - 0 rt, 1 const 4, 2 sext imm, 3 sext imm<<2, 4 zext imm, 5 imm<<16
//   alu_op     - 0 ADD .. 10 SRA
//   reg_write  - register file write enable
//   reg_dst    - 0 rt, 1 rd, 2 $31
//   wb_src     - 0 ALUOut, 1 MDR, 2 PC
//   instr_done - pulse on an instruction's final cycle
//   illegal    - sticky unsupported opcode/funct flag
//   bus_error  - sticky memory timeout flag
//
// State      | meaning
// -----------+---------------------------------------------------------
// FETCH      | read instruction at PC, PC <= PC+4 on ready
// DECODE     | branch target into ALUOut, dispatch on opcode
// RTYPE_EX   | register-register ALU op, or jr
// RTYPE_WB   | write ALUOut to rd
// ITYPE_EX   | register-immediate ALU op
// ITYPE_WB   | write ALUOut to rt
// MEMADR     | effective address rs + sext imm
// MEMRD      | load data read, MDR latches on ready
// MEMWB      | write MDR to rt
// MEMWR      | store data write
// BRANCH     | compare rs/rt, conditionally load branch target
// JUMP       | j/jal target, jal links $31
// HALT       | stopped after illegal instruction or bus error

module mips32i_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_RTYPE_EX, S_RTYPE_WB, S_ITYPE_EX, S_ITYPE_WB,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Counter holds "wait cycles already spent" in the current memory state,
    // so it only needs to reach MEM_WAIT_MAX-1.
    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          illegal_q, bus_error_q;
    logic          set_illegal;
    logic          mem_state;
    logic          timeout;

    always_comb begin
        mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
        // Timeout fires on the last allowed cycle only if ready is still low,
        // so a ready on that cycle completes normally.
        timeout   = (MEM_WAIT_MAX != 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_illegal) illegal_q   <= 1'b1;
            if (timeout)     bus_error_q <= 1'b1;
            if (!mem_state || state_nxt != state) begin
                wait_cnt <= '0;
            end else if (!mem_ready && MEM_WAIT_MAX != 0) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 3'd0;
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        wb_src      = 2'd0;
        instr_done  = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 3'd1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_b = 3'd3;
                if (opcode == OP_RTYPE)                       state_nxt = S_RTYPE_EX;
                else if (opcode == OP_LW || opcode == OP_SW)  state_nxt = S_MEMADR;
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_nxt = S_BRANCH;
                else if (opcode == OP_J || opcode == OP_JAL)  state_nxt = S_JUMP;
                else if (opcode[5:3] == 3'b001)               state_nxt = S_ITYPE_EX;
                else begin
                    state_nxt   = S_HALT;
                    set_illegal = 1'b1;
                end
            end
            S_RTYPE_EX: begin
                state_nxt = S_RTYPE_WB;
                alu_src_a = 2'd1;
                case (funct)
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24:        alu_op = ALU_AND;
                    6'h25:        alu_op = ALU_OR;
                    6'h26:        alu_op = ALU_XOR;
                    6'h27:        alu_op = ALU_NOR;
                    6'h2A:        alu_op = ALU_SLT;
                    6'h2B:        alu_op = ALU_SLTU;
                    6'h00: begin alu_src_a = 2'd2; alu_op = ALU_SLL; end
                    6'h02: begin alu_src_a = 2'd2; alu_op = ALU_SRL; end
                    6'h03: begin alu_src_a = 2'd2; alu_op = ALU_SRA; end
                    6'h08: begin
                        alu_src_a  = 2'd0;
                        pc_write   = 1'b1;
                        pc_src     = 2'd3;
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                    default: begin
                        alu_src_a   = 2'd0;
                        state_nxt   = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ITYPE_EX: begin
                alu_src_a = 2'd1;
                state_nxt = S_ITYPE_WB;
                // Decode only reaches here for 0x08-0x0F, so opcode[2:0] selects.
                case (opcode[2:0])
                    3'd0, 3'd1: begin alu_src_b = 3'd2; alu_op = ALU_ADD;  end
                    3'd2:       begin alu_src_b = 3'd2; alu_op = ALU_SLT;  end
                    3'd3:       begin alu_src_b = 3'd2; alu_op = ALU_SLTU; end
                    3'd4:       begin alu_src_b = 3'd4; alu_op = ALU_AND;  end
                    3'd5:       begin alu_src_b = 3'd4; alu_op = ALU_OR;   end
                    3'd6:       begin alu_src_b = 3'd4; alu_op = ALU_XOR;  end
                    default:    begin alu_src_b = 3'd5; alu_op = ALU_OR;   end
                endcase
            end
            S_ITYPE_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 2'd1;
                alu_src_b = 3'd2;
                state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)    state_nxt = S_MEMWB;
                else if (timeout) state_nxt = S_HALT;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                wb_src     = 2'd1;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_op     = ALU_SUB;
                pc_src     = 2'd1;
                pc_write   = (opcode == OP_BNE) ? !alu_zero : alu_zero;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
                if (opcode == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    wb_src    = 2'd2;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // Reset cycle: nothing may be written or requested.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            alu_src_a  = 2'd0;
            alu_src_b  = 3'd0;
            alu_op     = ALU_ADD;
            reg_write  = 1'b0;
            reg_dst    = 2'd0;
            wb_src     = 2'd0;
            instr_done = 1'b0;
        end
    end

    assign illegal   = illegal_q & ~rst;
    assign bus_error = bus_error_q & ~rst;

endmodule

// File: tb/tb_mips32i_multicycle_ctrl.sv
// Testbench for mips32i_multicycle_ctrl. Each instruction is expanded into a
// per-cycle list of expected control words from the instruction-class rules,
// then played against the DUT one cycle at a time.

module tb_mips32i_multicycle_ctrl;

    localparam int WMAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_a, reg_dst, wb_src;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write, instr_done, illegal, bus_error;

    mips32i_multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
        .instr_done(instr_done), .illegal(illegal), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [23:0] exp;
        string       tag;
    } cyc_t;

    cyc_t       q[$];
    int         checks = 0;
    int         errors = 0;
    bit         ill_m = 0, bus_m = 0;
    logic [5:0] cur_op, cur_fn;
    string      cur_name;
    int         cyc_idx;

    // Control word order: req we iord irw pcw pcs sa sb aluop rw rd wb done
    function automatic logic [21:0] c(int req, int we, int io, int irw, int pcw, int pcs,
                                      int sa, int sb, int aop, int rw, int rd, int wb, int done);
        return {1'(req), 1'(we), 1'(io), 1'(irw), 1'(pcw), 2'(pcs), 2'(sa), 3'(sb),
                4'(aop), 1'(rw), 2'(rd), 2'(wb), 1'(done)};
    endfunction

    task automatic push(logic rdy, logic [21:0] ctl, logic z);
        cyc_t e;
        e.rst = 1'b0; e.rdy = rdy; e.zero = z; e.op = cur_op; e.fn = cur_fn;
        e.exp = {ctl, ill_m, bus_m};
        cyc_idx++;
        e.tag = $sformatf("%s c%0d", cur_name, cyc_idx);
        q.push_back(e);
    endtask

    // Cycles where mem_ready must be ignored get random ready/zero.
    task automatic push_any(logic [21:0] ctl);
        push(1'($urandom), ctl, 1'($urandom));
    endtask

    task automatic push_reset();
        cyc_t e;
        e.rst = 1'b1; e.rdy = 1'($urandom); e.zero = 1'($urandom);
        e.op = 6'($urandom); e.fn = 6'($urandom); e.exp = '0;
        e.tag = $sformatf("%s reset", cur_name);
        q.push_back(e);
        ill_m = 0;
        bus_m = 0;
    endtask

    task automatic halt_tail();
        push_any('0);
        push_any('0);
        push_reset();
    endtask

    // w wait cycles then a ready cycle; w >= WMAX means no ready in time.
    task automatic mem_phase(logic [21:0] wait_ctl, logic [21:0] rdy_ctl, int w, output bit to);
        if (w >= WMAX) begin
            repeat (WMAX) push(1'b0, wait_ctl, 1'($urandom));
            bus_m = 1;
            to = 1;
        end else begin
            repeat (w) push(1'b0, wait_ctl, 1'($urandom));
            push(1'b1, rdy_ctl, 1'($urandom));
            to = 0;
        end
    endtask

    function automatic int r_alu(logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 0;
            6'h22, 6'h23: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h26: return 4;
            6'h27: return 5;
            6'h2A: return 6;
            6'h2B: return 7;
            6'h00: return 8;
            6'h02: return 9;
            6'h03: return 10;
            default: return -1;
        endcase
    endfunction

    task automatic begin_instr(logic [5:0] op, logic [5:0] fn, string name);
        cur_op = op; cur_fn = fn; cur_name = name; cyc_idx = 0;
    endtask

    task automatic model_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw, logic z, string name);
        bit to;
        int a;
        begin_instr(op, fn, name);
        mem_phase(c(1,0,0,0,0,0,0,1,0,0,0,0,0), c(1,0,0,1,1,0,0,1,0,0,0,0,0), fw, to);
        if (to) begin halt_tail(); return; end
        push_any(c(0,0,0,0,0,0,0,3,0,0,0,0,0));
        if (op == 6'h00) begin
            a = r_alu(fn);
            if (fn == 6'h08) begin
                push_any(c(0,0,0,0,1,3,0,0,0,0,0,0,1));
            end else if (a < 0) begin
                push_any('0);
                ill_m = 1;
                halt_tail();
            end else begin
                push_any(c(0,0,0,0,0,0,(a >= 8) ? 2 : 1,0,a,0,0,0,0));
                push_any(c(0,0,0,0,0,0,0,0,0,1,1,0,1));
            end
        end else if (op == 6'h23) begin
            push_any(c(0,0,0,0,0,0,1,2,0,0,0,0,0));
            mem_phase(c(1,0,1,0,0,0,0,0,0,0,0,0,0), c(1,0,1,0,0,0,0,0,0,0,0,0,0), mw, to);
            if (to) begin halt_tail(); return; end
            push_any(c(0,0,0,0,0,0,0,0,0,1,0,1,1));
        end else if (op == 6'h2B) begin
            push_any(c(0,0,0,0,0,0,1,2,0,0,0,0,0));
            mem_phase(c(1,1,1,0,0,0,0,0,0,0,0,0,0), c(1,1,1,0,0,0,0,0,0,0,0,0,1), mw, to);
            if (to) halt_tail();
        end else if (op == 6'h04 || op == 6'h05) begin
            push(1'($urandom), c(0,0,0,0,(op == 6'h04) ? int'(z) : int'(!z),1,1,0,1,0,0,0,1), z);
        end else if (op == 6'h02) begin
            push_any(c(0,0,0,0,1,2,0,0,0,0,0,0,1));
        end else if (op == 6'h03) begin
            push_any(c(0,0,0,0,1,2,0,0,0,1,2,2,1));
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            case (op)
                6'h08, 6'h09: push_any(c(0,0,0,0,0,0,1,2,0,0,0,0,0));
                6'h0A:        push_any(c(0,0,0,0,0,0,1,2,6,0,0,0,0));
                6'h0B:        push_any(c(0,0,0,0,0,0,1,2,7,0,0,0,0));
                6'h0C:        push_any(c(0,0,0,0,0,0,1,4,2,0,0,0,0));
                6'h0D:        push_any(c(0,0,0,0,0,0,1,4,3,0,0,0,0));
                6'h0E:        push_any(c(0,0,0,0,0,0,1,4,4,0,0,0,0));
                default:      push_any(c(0,0,0,0,0,0,1,5,3,0,0,0,0));
            endcase
            push_any(c(0,0,0,0,0,0,0,0,0,1,0,0,1));
        end else begin
            ill_m = 1;
            halt_tail();
        end
    endtask

    task automatic run_queue();
        cyc_t        e;
        logic [23:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; alu_zero = e.zero;
            opcode = e.op; funct = e.fn;
            #1;
            obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                   alu_op, reg_write, reg_dst, wb_src, instr_done, illegal, bus_error};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    logic [5:0] r_ops[15] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                              6'h03, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0E, 6'h0F};
    logic [5:0] r_fns[12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h08};
    logic [5:0] bad_ops[4] = '{6'h01, 6'h06, 6'h20, 6'h3F};
    logic [5:0] bad_fns[3] = '{6'h01, 6'h09, 6'h30};

    initial begin
        bit   to;
        logic [5:0] op, fn;
        int   fw, mw;

        begin_instr(6'h00, 6'h00, "rst");
        push_reset();
        push_reset();
        model_instr(6'h00, 6'h20, 0, 0, 1'b0, "add");
        model_instr(6'h23, 6'h00, 0, 3, 1'b0, "lw_wait3");
        model_instr(6'h04, 6'h00, 0, 0, 1'b1, "beq_z1");
        model_instr(6'h05, 6'h00, 0, 0, 1'b1, "bne_z1");
        model_instr(6'h05, 6'h00, 1, 0, 1'b0, "bne_z0");
        model_instr(6'h03, 6'h00, 0, 0, 1'b0, "jal");
        model_instr(6'h00, 6'h08, 0, 0, 1'b0, "jr");
        model_instr(6'h2B, 6'h00, 2, 1, 1'b0, "sw");
        model_instr(6'h0F, 6'h00, 0, 0, 1'b0, "lui");
        model_instr(6'h00, 6'h03, 0, 0, 1'b0, "sra");
        // Reset in the middle of an add aborts it cleanly.
        begin_instr(6'h00, 6'h20, "abort");
        mem_phase(c(1,0,0,0,0,0,0,1,0,0,0,0,0), c(1,0,0,1,1,0,0,1,0,0,0,0,0), 0, to);
        push_any(c(0,0,0,0,0,0,0,3,0,0,0,0,0));
        push_reset();
        model_instr(6'h3F, 6'h00, 0, 0, 1'b0, "illegal_op");
        model_instr(6'h00, 6'h20, 0, 0, 1'b0, "add_after_rst");
        model_instr(6'h00, 6'h20, WMAX, 0, 1'b0, "fetch_timeout");
        model_instr(6'h00, 6'h24, WMAX - 1, 0, 1'b0, "fetch_last_ok");
        model_instr(6'h23, 6'h00, 0, WMAX + 1, 1'b0, "lw_timeout");
        model_instr(6'h2B, 6'h00, 0, WMAX - 1, 1'b0, "sw_last_ok");
        model_instr(6'h2B, 6'h00, 0, WMAX, 1'b0, "sw_timeout");
        model_instr(6'h00, 6'h3F, 0, 0, 1'b0, "illegal_fn");
        run_queue();

        for (int i = 0; i < 80; i++) begin
            op = r_ops[$urandom_range(0, 14)];
            fn = r_fns[$urandom_range(0, 11)];
            if ($urandom_range(0, 19) == 0) op = bad_ops[$urandom_range(0, 3)];
            if ($urandom_range(0, 19) == 0) fn = bad_fns[$urandom_range(0, 2)];
            fw = ($urandom_range(0, 15) == 0) ? $urandom_range(WMAX, WMAX + 1) : $urandom_range(0, WMAX - 1);
            mw = ($urandom_range(0, 15) == 0) ? $urandom_range(WMAX, WMAX + 1) : $urandom_range(0, WMAX - 1);
            model_instr(op, fn, fw, mw, 1'($urandom), $sformatf("rnd%0d_op%0h_fn%0h", i, op, fn));
            run_queue();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
